register_bank_mp: RTL

REGISTER_BANK_MP -- requirements
Module: register_bank_mp

---
 rtl/regbank_pkg.sv | 20 ++
 rtl/regbank_rdport.sv | 47 ++++
 rtl/register_bank_mp.sv | 115 +++++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regbank_pkg
// Purpose  : Shared types and default sizing for the multi-port register bank.
// Revision : 1.0 - initial release
// ============================================================================
package regbank_pkg;

  localparam int DEF_DEPTH = 32;
  localparam int DEF_BITS  = 64;
  localparam int DEF_NREAD = 2;

  // Sweep controller states
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage : regbank_pkg
`default_nettype wire

// File: rtl/regbank_rdport.sv
`default_nettype none
// ============================================================================
// Module   : regbank_rdport
// Purpose  : One registered read port: zero while clearing, optional
//            write-to-read forwarding, otherwise the addressed array entry.
// Revision : 1.0 - initial release
// ============================================================================
module regbank_rdport
  import regbank_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic [BITS-1:0] arr_data_i,
  input  logic            byp_hit_i,
  input  logic [BITS-1:0] byp_data_i,
  output logic [BITS-1:0] rdata_o
);

  logic [BITS-1:0] rdata_q;
  logic [BITS-1:0] rdata_d;

  // Select what the port captures this cycle; clearing has priority
  always_comb begin
    rdata_d = arr_data_i;
    if (clear_i) begin
      rdata_d = '0;
    end else if (byp_hit_i) begin
      rdata_d = byp_data_i;
    end
  end

  // Read data register, forced to zero by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule : regbank_rdport
`default_nettype wire

// File: rtl/register_bank_mp.sv
`default_nettype none
// ============================================================================
// Module   : register_bank_mp
// Purpose  : DEPTH x BITS register bank, one write port, NREAD registered
//            read ports, zeroed by a DEPTH-cycle sweep after reset or clr.
//            Define REGBANK_BYPASS_EN to forward same-cycle writes to reads.
// Revision : 1.0 - initial release
// ============================================================================
module register_bank_mp
  import regbank_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int BITS     = DEF_BITS,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NREAD*$clog2(DEPTH)-1:0]  raddr,
  output logic [NREAD*BITS-1:0]           rdata,
  input  logic [$clog2(DEPTH)-1:0]        waddr,
  input  logic [BITS-1:0]                 wdata,
  input  logic                            wen,
  input  logic                            clr,
  output logic                            ready
);

  localparam int AW = $clog2(DEPTH);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] mem_q [DEPTH];
  logic            w_in_clear;
  logic            w_wr_en;

  assign w_in_clear = (state_q == CLEAR);
  assign ready      = (state_q == READY);

  // A write lands only when ready, not overridden by clr, and not to a
  // hardwired-zero register 0
  assign w_wr_en = !w_in_clear && wen && !clr &&
                   !((ZERO_REG != 0) && (waddr == '0));

  // Next-state logic: sweep runs DEPTH cycles, clr (re)starts it from 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State and sweep counter; reset always restarts a full sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array storage: not reset, zeroed one entry per cycle by the sweep
  always_ff @(posedge clk) begin
    if (w_in_clear) begin
      mem_q[cnt_q] <= '0;
    end else if (w_wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rdport
    logic [AW-1:0]   w_raddr;
    logic [BITS-1:0] w_arr;
    logic            w_hit;

    assign w_raddr = raddr[p*AW +: AW];
    assign w_arr   = ((ZERO_REG != 0) && (w_raddr == '0)) ? '0 : mem_q[w_raddr];
`ifdef REGBANK_BYPASS_EN
    assign w_hit   = w_wr_en && (w_raddr == waddr);
`else
    assign w_hit   = 1'b0;
`endif

    regbank_rdport #(
      .BITS (BITS)
    ) u_rdport (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (w_in_clear),
      .arr_data_i (w_arr),
      .byp_hit_i  (w_hit),
      .byp_data_i (wdata),
      .rdata_o    (rdata[p*BITS +: BITS])
    );
  end

endmodule : register_bank_mp
`default_nettype wire
